// File: rtl/otter_pkg.sv
// Shared OTTER control types: opcodes, control-unit states and the
// PC-source / register-file write-select encodings used by the decoder.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } cu_state_t;

    typedef enum logic [2:0] {
        PC_SRC_PLUS4  = 3'd0,
        PC_SRC_JALR   = 3'd1,
        PC_SRC_BRANCH = 3'd2,
        PC_SRC_JAL    = 3'd3,
        PC_SRC_MTVEC  = 3'd4,
        PC_SRC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        RF_WR_PC4 = 2'd0,
        RF_WR_CSR = 2'd1,
        RF_WR_MEM = 2'd2,
        RF_WR_ALU = 2'd3
    } rf_wr_sel_t;

    // Wide enough for INIT_CYCLES up to 15.
    localparam int unsigned INIT_CNT_W = 4;

endpackage

// File: rtl/otter_cu_fsm.sv
// Multicycle control-unit FSM for the OTTER RV32I MCU: sequences fetch,
// execute and load writeback, drives write/load strobes and counts retired
// instructions. Optional macro OTTER_INTR_EN adds the one-cycle ST_INTR entry.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int unsigned INSTRET_W   = 32,
    parameter int unsigned INIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 intr,
    input  logic                 mie,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 ir_load,
    output logic                 mem_rden1,
    output logic                 mem_rden2,
    output logic                 mem_we2,
    output logic                 rst_out,
    output logic                 int_taken,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

    cu_state_t             state_q, state_d;
    cu_state_t             done_state;
    logic [INIT_CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic                  retire;

    // SYSTEM is retired uniformly; the CSR unit handles func3 itself.
    logic unused_func3;
    assign unused_func3 = ^func3;

    // Where an instruction goes once it leaves EXEC/WB (interrupt checked only here).
`ifdef OTTER_INTR_EN
    assign done_state = (intr & mie) ? ST_INTR : ST_FETCH;
`else
    logic unused_irq;
    assign unused_irq = intr ^ mie;
    assign done_state = ST_FETCH;
`endif

    // State register, init counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            instret    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        ir_load    = 1'b0;
        mem_rden1  = 1'b0;
        mem_rden2  = 1'b0;
        mem_we2    = 1'b0;
        rst_out    = 1'b0;
        int_taken  = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            ST_INIT: begin
                rst_out = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_CNT_W'(1);
                end
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    LUI, AUIPC, OP, OP_IMM, JAL, JALR: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        retire    = 1'b1;
                        state_d   = done_state;
                    end
                    BRANCH, SYSTEM: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = done_state;
                    end
                    STORE: begin
                        mem_we2 = 1'b1;
                        if (dmem_ready) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = done_state;
                        end
                    end
                    LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = ST_WB;
                    end
                    default: begin
                        pc_write = 1'b1;
                        illegal  = 1'b1;
                        state_d  = done_state;
                    end
                endcase
            end
            ST_WB: begin
                mem_rden2 = 1'b1;
                if (dmem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_d   = done_state;
                end
            end
`ifdef OTTER_INTR_EN
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
`endif
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A reset cycle never lets a write or retire through, even mid-instruction.
        if (rst) begin
            retire    = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            ir_load   = 1'b0;
            mem_rden1 = 1'b0;
            mem_rden2 = 1'b0;
            mem_we2   = 1'b0;
            int_taken = 1'b0;
            illegal   = 1'b0;
            rst_out   = 1'b1;
        end
    end

endmodule
